// File: rtl/parking_occupancy_counter.sv
// parking_occupancy_counter
//   Front end of the parking-lot display path. Synchronises and debounces the
//   two gate photo-sensors, decodes the A/B blocking order into car-enter and
//   car-exit events, and keeps a saturating 8-bit occupancy count.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   i_sens_a       outer sensor, raw/asynchronous, 1 = beam blocked
//   i_sens_b       inner sensor, raw/asynchronous, 1 = beam blocked
//   i_clr          synchronous clear of count and sequence FSM
//   o_count        occupancy, 0..CAPACITY (feeds the binary-to-BCD converter)
//   o_full         o_count == CAPACITY
//   o_empty        o_count == 0
//   o_enter_pulse  one-cycle pulse on an accepted entry
//   o_exit_pulse   one-cycle pulse on an accepted exit
//   o_err_pulse    one-cycle pulse on a rejected event or illegal sequence
//
// state    | meaning
// ---------+----------------------------------------------
// S_IDLE   | both beams clear, waiting for a car
// S_EN1    | A blocked only (car entering)
// S_EN2    | A and B blocked (car entering)
// S_EN3    | B blocked only (car entering, about to finish)
// S_EX1    | B blocked only (car leaving)
// S_EX2    | B and A blocked (car leaving)
// S_EX3    | A blocked only (car leaving, about to finish)
// S_WAIT   | illegal sequence seen, wait for both beams clear
module parking_occupancy_counter #(
  parameter int CAPACITY = 200,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sens_a,
  input  logic       i_sens_b,
  input  logic       i_clr,
  output logic [7:0] o_count,
  output logic       o_full,
  output logic       o_empty,
  output logic       o_enter_pulse,
  output logic       o_exit_pulse,
  output logic       o_err_pulse
);

  localparam logic [7:0] CAP     = 8'(CAPACITY);
  // Counter reaching DEBOUNCE is detected one step early so the filter
  // updates on the same edge the count would have hit DEBOUNCE.
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_EN1, S_EN2, S_EN3, S_EX1, S_EX2, S_EX3, S_WAIT
  } state_t;

  logic [1:0] r_sync_a, r_sync_b;
  logic       r_af, r_bf;
  logic [7:0] r_cnt_a, r_cnt_b;
  state_t     r_state;
  logic [7:0] r_count;
  logic       r_enter, r_exit, r_err;
  logic [1:0] w_ab;

  assign w_ab = {r_af, r_bf};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_a <= '0;
      r_sync_b <= '0;
    end else begin
      r_sync_a <= {r_sync_a[0], i_sens_a};
      r_sync_b <= {r_sync_b[0], i_sens_b};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_af    <= 1'b0;
      r_cnt_a <= '0;
    end else if (r_sync_a[1] == r_af) begin
      r_cnt_a <= '0;
    end else if (r_cnt_a == DB_LAST) begin
      r_af    <= r_sync_a[1];
      r_cnt_a <= '0;
    end else begin
      r_cnt_a <= r_cnt_a + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bf    <= 1'b0;
      r_cnt_b <= '0;
    end else if (r_sync_b[1] == r_bf) begin
      r_cnt_b <= '0;
    end else if (r_cnt_b == DB_LAST) begin
      r_bf    <= r_sync_b[1];
      r_cnt_b <= '0;
    end else begin
      r_cnt_b <= r_cnt_b + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_enter <= 1'b0;
      r_exit  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_enter <= 1'b0;
      r_exit  <= 1'b0;
      r_err   <= 1'b0;
      if (i_clr) begin
        r_state <= S_IDLE;
        r_count <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            case (w_ab)
              2'b10:   r_state <= S_EN1;
              2'b01:   r_state <= S_EX1;
              2'b11:   begin r_state <= S_WAIT; r_err <= 1'b1; end
              default: ;
            endcase
          end
          S_EN1: begin
            case (w_ab)
              2'b11:   r_state <= S_EN2;
              2'b00:   r_state <= S_IDLE;
              2'b01:   begin r_state <= S_WAIT; r_err <= 1'b1; end
              default: ;
            endcase
          end
          S_EN2: begin
            case (w_ab)
              2'b01:   r_state <= S_EN3;
              2'b10:   r_state <= S_EN1;
              2'b00:   r_state <= S_IDLE;
              default: ;
            endcase
          end
          S_EN3: begin
            case (w_ab)
              2'b00: begin
                r_state <= S_IDLE;
                if (r_count < CAP) begin
                  r_count <= r_count + 8'd1;
                  r_enter <= 1'b1;
                end else begin
                  r_err <= 1'b1;
                end
              end
              2'b11:   r_state <= S_EN2;
              2'b10:   begin r_state <= S_WAIT; r_err <= 1'b1; end
              default: ;
            endcase
          end
          S_EX1: begin
            case (w_ab)
              2'b11:   r_state <= S_EX2;
              2'b00:   r_state <= S_IDLE;
              2'b10:   begin r_state <= S_WAIT; r_err <= 1'b1; end
              default: ;
            endcase
          end
          S_EX2: begin
            case (w_ab)
              2'b10:   r_state <= S_EX3;
              2'b01:   r_state <= S_EX1;
              2'b00:   r_state <= S_IDLE;
              default: ;
            endcase
          end
          S_EX3: begin
            case (w_ab)
              2'b00: begin
                r_state <= S_IDLE;
                if (r_count != 8'd0) begin
                  r_count <= r_count - 8'd1;
                  r_exit  <= 1'b1;
                end else begin
                  r_err <= 1'b1;
                end
              end
              2'b11:   r_state <= S_EX2;
              2'b01:   begin r_state <= S_WAIT; r_err <= 1'b1; end
              default: ;
            endcase
          end
          S_WAIT: begin
            if (w_ab == 2'b00) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_count       = r_count;
  assign o_full        = (r_count == CAP);
  assign o_empty       = (r_count == 8'd0);
  assign o_enter_pulse = r_enter;
  assign o_exit_pulse  = r_exit;
  assign o_err_pulse   = r_err;

endmodule

// File: tb/tb_parking_occupancy_counter.sv
// Directed bench: u_dut uses default parameters, u_sat uses CAPACITY=3.
// Both share the same stimulus.
module tb_parking_occupancy_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic sens_a = 1'b0;
  logic sens_b = 1'b0;
  logic clr = 1'b0;

  logic [7:0] d_count, s_count;
  logic d_full, d_empty, d_enter, d_exit, d_err;
  logic s_full, s_empty, s_enter, s_exit, s_err;

  int n_vec = 0;
  int n_err = 0;
  int d_ent_n = 0, d_ext_n = 0, d_err_n = 0;
  int s_ent_n = 0, s_ext_n = 0, s_err_n = 0;
  int b_d_ent, b_d_ext, b_d_err, b_s_ent, b_s_ext, b_s_err;

  parking_occupancy_counter u_dut (
    .clk(clk), .rst_n(rst_n), .i_sens_a(sens_a), .i_sens_b(sens_b), .i_clr(clr),
    .o_count(d_count), .o_full(d_full), .o_empty(d_empty),
    .o_enter_pulse(d_enter), .o_exit_pulse(d_exit), .o_err_pulse(d_err)
  );

  parking_occupancy_counter #(.CAPACITY(3), .DEBOUNCE(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .i_sens_a(sens_a), .i_sens_b(sens_b), .i_clr(clr),
    .o_count(s_count), .o_full(s_full), .o_empty(s_empty),
    .o_enter_pulse(s_enter), .o_exit_pulse(s_exit), .o_err_pulse(s_err)
  );

  always #5 clk = ~clk;

  // Pulse tallies, sampled shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    if (d_enter) d_ent_n++;
    if (d_exit)  d_ext_n++;
    if (d_err)   d_err_n++;
    if (s_enter) s_ent_n++;
    if (s_exit)  s_ext_n++;
    if (s_err)   s_err_n++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_d_ent = d_ent_n; b_d_ext = d_ext_n; b_d_err = d_err_n;
    b_s_ent = s_ent_n; b_s_ext = s_ext_n; b_s_err = s_err_n;
  endtask

  // Call at a falling edge; drives the raw sensors and holds n cycles.
  task automatic hold(input logic a, input logic b, input int n);
    sens_a = a;
    sens_b = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic entry();
    hold(1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 10);
    hold(1'b0, 1'b1, 10);
    hold(1'b0, 1'b0, 10);
  endtask

  task automatic leave();
    hold(1'b0, 1'b1, 10);
    hold(1'b1, 1'b1, 10);
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 10);
  endtask

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_count_async", int'(d_count), 0);
    repeat (3) @(negedge clk);
    chk("rst_count", int'(d_count), 0);
    chk("rst_empty", int'(d_empty), 1);
    chk("rst_full", int'(d_full), 0);
    chk("rst_pulses", int'({d_enter, d_exit, d_err}), 0);
    rst_n = 1'b1;
    hold(1'b0, 1'b0, 4);

    // Clean entry, pulse 7 cycles after final release
    snap();
    hold(1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 10);
    hold(1'b0, 1'b1, 10);
    chk("entry_count_before", int'(d_count), 0);
    sens_a = 1'b0;
    sens_b = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("entry_pulse_cyc%0d", k), int'(d_enter), (k == 7) ? 1 : 0);
    end
    repeat (2) @(negedge clk);
    chk("entry_count", int'(d_count), 1);
    chk("entry_empty", int'(d_empty), 0);
    chk("entry_n_enter", d_ent_n - b_d_ent, 1);
    chk("entry_n_err", d_err_n - b_d_err, 0);

    // Exit then underflow
    snap();
    leave();
    chk("exit_count", int'(d_count), 0);
    chk("exit_empty", int'(d_empty), 1);
    chk("exit_n_exit", d_ext_n - b_d_ext, 1);
    chk("exit_n_err", d_err_n - b_d_err, 0);
    snap();
    leave();
    chk("under_count", int'(d_count), 0);
    chk("under_n_err", d_err_n - b_d_err, 1);
    chk("under_n_exit", d_ext_n - b_d_ext, 0);

    // Entry abort A -> AB -> A -> none
    snap();
    hold(1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 10);
    hold(1'b1, 1'b0, 10);
    hold(1'b0, 1'b0, 10);
    chk("abort_pulses", (d_ent_n - b_d_ent) + (d_ext_n - b_d_ext) + (d_err_n - b_d_err), 0);
    chk("abort_count", int'(d_count), 0);

    // 3-cycle glitch on A
    snap();
    hold(1'b1, 1'b0, 3);
    hold(1'b0, 1'b0, 12);
    chk("glitch_pulses", (d_ent_n - b_d_ent) + (d_ext_n - b_d_ext) + (d_err_n - b_d_err), 0);

    // Both sensors together from IDLE
    snap();
    hold(1'b1, 1'b1, 10);
    chk("both_n_err", d_err_n - b_d_err, 1);
    chk("both_count", int'(d_count), 0);
    hold(1'b0, 1'b0, 10);
    chk("both_n_err_after", d_err_n - b_d_err, 1);
    chk("both_n_enter", d_ent_n - b_d_ent, 0);

    // EN3 seeing 10
    snap();
    hold(1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 10);
    hold(1'b0, 1'b1, 10);
    hold(1'b1, 1'b0, 10);
    chk("en3_10_n_err", d_err_n - b_d_err, 1);
    hold(1'b0, 1'b0, 10);
    chk("en3_10_n_enter", d_ent_n - b_d_ent, 0);
    chk("en3_10_count", int'(d_count), 0);

    // Saturation on the CAPACITY=3 instance
    snap();
    entry();
    chk("sat_count1", int'(s_count), 1);
    entry();
    chk("sat_count2", int'(s_count), 2);
    chk("sat_full2", int'(s_full), 0);
    entry();
    chk("sat_count3", int'(s_count), 3);
    chk("sat_full3", int'(s_full), 1);
    chk("sat_n_enter", s_ent_n - b_s_ent, 3);
    snap();
    entry();
    chk("sat_count4", int'(s_count), 3);
    chk("sat_n_err4", s_err_n - b_s_err, 1);
    chk("sat_n_enter4", s_ent_n - b_s_ent, 0);
    chk("sat_dflt_count4", int'(d_count), 4);

    // Reset while in EN2 with count 5
    entry();
    chk("mid_count5", int'(d_count), 5);
    hold(1'b1, 1'b0, 10);
    hold(1'b1, 1'b1, 10);
    snap();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", int'(d_count), 0);
    chk("mid_rst_empty", int'(d_empty), 1);
    @(negedge clk);
    hold(1'b0, 1'b0, 3);
    rst_n = 1'b1;
    hold(1'b0, 1'b0, 12);
    chk("mid_rst_pulses", (d_ent_n - b_d_ent) + (d_ext_n - b_d_ext) + (d_err_n - b_d_err), 0);
    chk("mid_rst_count_after", int'(d_count), 0);

    // Clear at count 7
    repeat (7) entry();
    chk("clr_count7", int'(d_count), 7);
    clr = 1'b1;
    #1;
    chk("clr_count_pre_edge", int'(d_count), 7);
    @(negedge clk);
    chk("clr_count", int'(d_count), 0);
    chk("clr_empty", int'(d_empty), 1);
    clr = 1'b0;
    hold(1'b0, 1'b0, 4);
    entry();
    chk("clr_entry_after", int'(d_count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/parking_occupancy_counter.md
# parking_occupancy_counter

Upstream stage of the parking-lot display path. Takes the two raw gate photo-sensors (outer A, inner B), synchronises and debounces them, and decodes the A/B blocking sequence into car-enter and car-exit events with a direction-tracking FSM. It also maintains a saturating 8-bit occupancy count. `count` drives the 8-bit binary input of the binary-to-BCD converter directly.

## Interface
- `CAPACITY`, default 200: maximum occupancy; legal range 1..255.
- `DEBOUNCE`, default 4: consecutive stable synchronised samples required before a sensor change is accepted; legal range 1..255.
- `clk` input, 1: system clock; all logic is rising-edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `sens_a` input, 1: outer sensor, raw and asynchronous; 1 = beam blocked.
- `sens_b` input, 1: inner sensor, raw and asynchronous; 1 = beam blocked.
- `clr` input, 1: synchronous clear of count and FSM.
- `count` output, 8: current occupancy in binary, 0..CAPACITY.
- `full` output, 1: `count == CAPACITY`.
- `empty` output, 1: `count == 0`.
- `enter_pulse` output, 1: one-cycle pulse when a valid entry increments the count.
- `exit_pulse` output, 1: one-cycle pulse when a valid exit decrements the count.
- `err_pulse` output, 1: one-cycle pulse on a rejected event: entry while full, exit while empty, or an illegal sequence.

## Operation
- **Synchroniser:** each sensor passes through 2 flops.
- **Debounce:** each sensor has a filtered value `af`/`bf` and its own stability counter.
  - The counter resets whenever the synchronised value equals the filtered value.
  - Otherwise it increments. When it reaches DEBOUNCE, the filtered value takes the synchronised value and the counter clears.
- **FSM:** states are IDLE, EN1, EN2, EN3, EX1, EX2, EX3, WAIT_CLR. The input is `{af,bf}`; any input not listed for a state holds that state.
  - IDLE: 10→EN1; 01→EX1; 11→WAIT_CLR.
  - EN1: 11→EN2; 00→IDLE (abort, no count); 01→WAIT_CLR.
  - EN2: 01→EN3; 10→EN1; 00→IDLE (no count).
  - EN3: 00→IDLE with an entry event; 11→EN2; 10→WAIT_CLR.
  - EX1/EX2/EX3 mirror EN1/EN2/EN3 with A and B swapped. EX3 exits on 00→IDLE with an exit event.
  - WAIT_CLR: 00→IDLE. Every transition into WAIT_CLR raises `err_pulse`.
- **Entry event:**
  - If `count < CAPACITY`: `count += 1` and `enter_pulse`.
  - Else: count unchanged and `err_pulse` (no wrap).
- **Exit event:**
  - If `count > 0`: `count -= 1` and `exit_pulse`.
  - Else: count unchanged and `err_pulse` (no wrap below 0).
- **Clear:** `clr` = 1 forces `count` = 0 and FSM = IDLE, and suppresses all pulses that cycle. The synchroniser and debounce stages keep running.
  - If a sensor is still blocked when `clr` deasserts, the FSM evaluates it from IDLE on the next cycle.
- **Flags:** `full` and `empty` are decoded combinationally from the registered `count`.
- **Event concurrency:** at most one event can occur per cycle by construction; no simultaneous increment/decrement case exists.

## Timing
- **Reset values** (on `rst_n` = 0, immediately and asynchronously):
  - `count` = 0, `empty` = 1, `full` = 0.
  - All pulses 0.
  - FSM = IDLE.
  - Synchroniser flops and `af`/`bf` = 0; stability counters = 0.
- **Reset mid-sequence:** any partial sequence is discarded; no event is generated on release.
- **Filter latency:** with a raw input change held stable from before edge 1, the synchronised value is valid after edge 2. The filtered value changes on edge 2+DEBOUNCE.
- **Glitch rejection:** a raw pulse shorter than DEBOUNCE clocks (after synchronisation) never reaches `af`/`bf`.
- **FSM latency:** the FSM transitions on the edge following the filtered change, i.e. edge 3+DEBOUNCE.
- **Outputs:** `count` and the pulses update on that same edge. Pulses are registered, last exactly 1 cycle, and are mutually exclusive.
- **Output timing:** `count` is registered and stable for the whole cycle, so the downstream combinational BCD converter output settles within the same cycle.

## Test plan
- **Clean entry** (CAPACITY=200, DEBOUNCE=4): drive A=1; then A=1,B=1; then A=0,B=1; then both 0, each step held 10 cycles. Required: one `enter_pulse` exactly 7 cycles after the final raw release; `count` 0→1; `empty` 1→0.
- **Exit and underflow:** from `count`=1, apply the mirrored B→A sequence twice. Required: first pass gives `exit_pulse` with `count`=0, `empty`=1; second pass gives `err_pulse` with `count` held at 0.
- **Saturation** (CAPACITY=3): apply 4 valid entries. Required: `count` reads 1, 2, 3; `full`=1 after the third; the fourth gives `err_pulse` only, with `count` still 3.
- **Aborts and glitches:**
  - A=1 → A=1,B=1 → A=1 → 00: no pulse, `count` unchanged.
  - A 3-cycle glitch with DEBOUNCE=4: FSM stays IDLE, no outputs.
- **Illegal sequences:**
  - A and B assert simultaneously from IDLE: `err_pulse`, FSM in WAIT_CLR, no count change until both clear.
  - EN3 with input 10: `err_pulse`.
- **Reset and clear:**
  - `rst_n` asserted while in EN2 with `count`=5: `count`=0 immediately; releasing the sensors afterwards gives no pulse.
  - `clr` held 1 cycle at `count`=7: `count`=0 on the next edge.
